wave_overlay: RTL and testbench
===============================

Name: wave_overlay

Overview:
- Downstream consumer of the wave_former coordinate counter.
- Receives the video AXI-stream together with the per-beat x/y coordinates computed from that same handshake.
- Overlays a waveform trace held in a double-buffered sample memory: the pixel at column x is painted WAVE_COLOR when y equals the stored sample for x; otherwise video passes through.
- Samples arrive on a separate stream port and are committed to the display at the next start-of-frame.

Parameters:
- DATA_W, 24, pixel width (tdata).
- MAX_COLS, 1024, sample buffer depth per bank (max drawable columns); power of two.
- WAVE_COLOR, 24'hFFFFFF, overlay pixel value (DATA_W bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tuser  in  1  start of frame (sof)
- s_axis_tlast  in  1  end of line (eol)
- x  in  16  column of the current s_axis beat
- y  in  16  row of the current s_axis beat
- m_axis_tdata  out  DATA_W  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  delayed sof
- m_axis_tlast  out  1  delayed eol
- smp_valid  in  1  sample valid
- smp_ready  out  1  sample ready
- smp_data  in  16  sample value (row index)
- smp_last  in  1  last sample of a trace

Behaviour:
- Reset: one clock domain; reset is asynchronous, active-low on rst_n. All pipeline valids=0, m_axis_* = 0, smp_ready=1, active_bank=0, both bank lengths=0, wr_ptr=0, write state FILL. RAM contents are not reset.
- Video pipeline: two stages, latency 2 accepted beats. Global enable en = ~m_axis_tvalid | m_axis_tready. s_axis_tready = en.
  - Stage 1 (on en): registers tdata/tuser/tlast/y/valid and in_range = (x < len[rd_bank]). Issues the RAM read at address {rd_bank, x[ADDR_W-1:0]}.
  - Stage 2 (on en): hit = stage1 valid & in_range & (ram_q == y). m_axis_tdata = hit ? WAVE_COLOR : pixel. tuser/tlast are delayed.
  - When en=0 the stages hold their values and the RAM output is held (read enable = en).
- Bank select: rd_bank = (pending & beat_sof) ? ~active_bank : active_bank, where beat_sof = s_axis_tvalid & s_axis_tready & s_axis_tuser. The swap therefore applies to the sof beat itself.
- Write side FSM:
  - FILL: smp_ready=1. On each accepted sample, write RAM[{~active_bank, wr_ptr}] and increment wr_ptr. When smp_last is accepted, or a write lands at wr_ptr == MAX_COLS-1: record len[~active_bank] = wr_ptr+1, set pending, go to FULL.
  - FULL: smp_ready=0. On beat_sof: toggle active_bank, clear pending, wr_ptr=0, go to FILL.
- Boundaries:
  - x >= len or x >= MAX_COLS: never a hit.
  - A sample commit and a sof beat in the same cycle: no swap (pending was 0); the swap happens at the following sof.
  - Repeated sof while in FILL: no effect on the write side.
  - Reset mid-frame: the partial trace is discarded; no overlay until the first commit plus a sof.
  - len=0: pure pass-through.
- Widths: compare is the full 16 bits. Only x[ADDR_W-1:0] addresses the RAM, with ADDR_W = $clog2(MAX_COLS).

Optional Feature:
- Macro: WAVE_OVERLAY_FILL_EN.
- Defined: hit = in_range & (y >= ram_q), which fills the area below the trace (y grows downward).
- Undefined: equality only, giving a one-pixel trace.
- Latency and handshake are identical in both cases.

Decomposition:
- wave_former_pkg: coord_t (logic [15:0]), wr_state_t enum {WR_FILL, WR_FULL}, and function addr_w(MAX_COLS).
- Sub-module wave_sample_ram: simple dual-port RAM, 2*MAX_COLS x 16. Synchronous write; synchronous 1-cycle read with read enable.

Test Plan:
- Reset, no samples; frame of 8x4 pixels with tdata=24'h123456 -> output identical to input, delayed by 2 beats, tuser/tlast aligned.
- Load samples 0,1,2,3 with last on the 4th, then sof -> rows 0..3 hit at columns 0..3 (24'hFFFFFF); columns 4..7 pass through; smp_ready=0 after the 4th sample until the sof beat.
- Second trace 3,3,3,3 loaded mid-frame -> current frame still draws the diagonal; next frame draws row 3 only; the swap is visible on the sof pixel (x=0, y=0 not a hit).
- Random m_axis_tready (50%) during a frame -> no beats lost or duplicated, output order preserved, s_axis_tready deasserts exactly when output is stalled.
- MAX_COLS+3 samples without last -> commit at MAX_COLS; x >= MAX_COLS never hits; extra samples are stalled until sof.
- rst_n pulsed mid-frame after commit -> m_axis_tvalid=0 immediately; next frame is pass-through. With WAVE_OVERLAY_FILL_EN, a trace of value 2 gives hits for all y >= 2.

Source files
------------

// File: rtl/wave_former_pkg.sv
// wave_former_pkg: types and helpers shared by the wave overlay slice.
//   coord_t    : 16-bit pixel coordinate / sample value
//   wr_state_t : sample write-side state (WR_FILL, WR_FULL)
//   addr_w()   : RAM address width for a given per-bank column count
package wave_former_pkg;

  typedef logic [15:0] coord_t;

  typedef enum logic {
    WR_FILL,
    WR_FULL
  } wr_state_t;

  function automatic int unsigned addr_w(input int unsigned max_cols);
    return (max_cols > 1) ? $clog2(max_cols) : 1;
  endfunction

endpackage

// File: rtl/wave_sample_ram.sv
// wave_sample_ram: simple dual-port sample memory, DEPTH x 16.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable; rdata updates one cycle after re, otherwise holds
//   raddr : read address
//   rdata : registered read data
// Contents are not reset.
module wave_sample_ram
  import wave_former_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  coord_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output coord_t        rdata
);

  coord_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wave_overlay.sv
// wave_overlay: paints a waveform trace over an AXI-stream video feed.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_axis_*          : input video (tuser = sof, tlast = eol)
//   x, y              : coordinates of the current s_axis beat
//   m_axis_*          : output video, 2 accepted beats of latency
//   smp_valid/ready   : sample stream handshake
//   smp_data          : sample value (row index), smp_last ends a trace
// A committed trace is displayed from the next sof beat onward.
// Build option WAVE_OVERLAY_FILL_EN: hit when y >= sample (area fill)
// instead of y == sample (one-pixel trace).
module wave_overlay
  import wave_former_pkg::*;
#(
  parameter int unsigned        DATA_W     = 24,
  parameter int unsigned        MAX_COLS   = 1024,
  parameter logic [DATA_W-1:0]  WAVE_COLOR = DATA_W'(24'hFFFFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [15:0]       smp_data,
  input  logic              smp_last
);

  localparam int unsigned ADDR_W = addr_w(MAX_COLS);
  localparam int unsigned LEN_W  = ADDR_W + 1;

  logic              en;
  logic              beat_sof;
  logic              pending;
  logic              rd_bank;
  logic              smp_fire;
  logic              wr_done;
  logic              in_range_c;
  logic              hit;
  logic [LEN_W-1:0]  len_rd;

  wr_state_t         wr_state;
  logic              active_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic [LEN_W-1:0]  len [2];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_user;
  logic              s1_last;
  coord_t            s1_y;
  logic              s1_in_range;
  coord_t            ram_q;

  assign en            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en;
  assign beat_sof      = s_axis_tvalid & en & s_axis_tuser;

  // A committed-but-not-displayed trace exists exactly while in WR_FULL.
  assign pending  = (wr_state == WR_FULL);
  assign rd_bank  = (pending & beat_sof) ? ~active_bank : active_bank;
  assign len_rd   = len[rd_bank];
  assign in_range_c = (32'(x) < 32'(len_rd));

  assign smp_fire = smp_valid & smp_ready;
  assign wr_done  = smp_last | (wr_ptr == ADDR_W'(MAX_COLS - 1));

  wave_sample_ram #(
    .DEPTH (2 * MAX_COLS),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (smp_fire),
    .waddr ({~active_bank, wr_ptr}),
    .wdata (smp_data),
    .re    (en),
    .raddr ({rd_bank, x[ADDR_W-1:0]}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= WR_FILL;
      active_bank <= 1'b0;
      wr_ptr      <= '0;
      len[0]      <= '0;
      len[1]      <= '0;
      smp_ready   <= 1'b1;
    end else begin
      case (wr_state)
        WR_FILL: begin
          if (smp_fire) begin
            if (wr_done) begin
              len[~active_bank] <= LEN_W'(wr_ptr) + LEN_W'(1);
              wr_state          <= WR_FULL;
              smp_ready         <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end
        WR_FULL: begin
          if (beat_sof) begin
            active_bank <= ~active_bank;
            wr_ptr      <= '0;
            wr_state    <= WR_FILL;
            smp_ready   <= 1'b1;
          end
        end
        default: wr_state <= WR_FILL;
      endcase
    end
  end

`ifdef WAVE_OVERLAY_FILL_EN
  assign hit = s1_valid & s1_in_range & (s1_y >= ram_q);
`else
  assign hit = s1_valid & s1_in_range & (s1_y == ram_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      s1_user       <= 1'b0;
      s1_last       <= 1'b0;
      s1_y          <= '0;
      s1_in_range   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      s1_valid      <= s_axis_tvalid;
      s1_data       <= s_axis_tdata;
      s1_user       <= s_axis_tuser;
      s1_last       <= s_axis_tlast;
      s1_y          <= y;
      s1_in_range   <= in_range_c;
      m_axis_tvalid <= s1_valid;
      m_axis_tdata  <= hit ? WAVE_COLOR : s1_data;
      m_axis_tuser  <= s1_user;
      m_axis_tlast  <= s1_last;
    end
  end

endmodule

// File: tb/tb_wave_overlay.sv
`timescale 1ns/1ps
module tb_wave_overlay;

  localparam int unsigned DATA_W   = 24;
  localparam int unsigned MAX_COLS = 16;
  localparam logic [23:0] WAVE     = 24'hFFFFFF;
  localparam logic [23:0] PIX      = 24'h123456;
  localparam int          BUDGET   = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        smp_valid = 1'b0;
  logic        smp_ready;
  logic [15:0] smp_data = '0;
  logic        smp_last = 1'b0;

  always #5 clk = ~clk;

  wave_overlay #(
    .DATA_W     (DATA_W),
    .MAX_COLS   (MAX_COLS),
    .WAVE_COLOR (WAVE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .x             (x),
    .y             (y),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_data      (smp_data),
    .smp_last      (smp_last)
  );

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  int total = 0;
  int bad   = 0;

  // Reference model: traces as plain lists of sample values.
  beat_t exp_q[$];
  beat_t out_log[$];
  int    fill_q[$];
  int    pend_q[$];
  int    disp[$];
  bit    have_pend = 1'b0;

  int cyc = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  int smp_cnt = 0;
  int first_in_cyc = -1;
  int first_out_cyc = -1;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_pix(input int xx, input int yy, input logic [23:0] d);
    if (xx >= disp.size() || xx >= int'(MAX_COLS)) return d;
`ifdef WAVE_OVERLAY_FILL_EN
    return (yy >= disp[xx]) ? WAVE : d;
`else
    return (yy == disp[xx]) ? WAVE : d;
`endif
  endfunction

  // Compare process: checks every cycle against the model.
  always @(negedge clk) begin
    bit    rdy_model;
    beat_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      fill_q.delete();
      pend_q.delete();
      disp.delete();
      have_pend = 1'b0;
      check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
      check("rst_smp_ready", 32'(smp_ready), 32'd1);
    end else begin
      rdy_model = !have_pend;
      check("s_ready_rule", 32'(s_axis_tready), 32'(!m_axis_tvalid || m_axis_tready));
      check("smp_ready", 32'(smp_ready), 32'(rdy_model));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_axis_tdata), 32'(e.d));
          check("out_user", 32'(m_axis_tuser), 32'(e.u));
          check("out_last", 32'(m_axis_tlast), 32'(e.l));
        end
        out_log.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast});
        out_cnt++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (s_axis_tuser && have_pend) begin
          disp = pend_q;
          pend_q.delete();
          have_pend = 1'b0;
        end
        exp_q.push_back('{d: model_pix(int'(x), int'(y), s_axis_tdata),
                          u: s_axis_tuser, l: s_axis_tlast});
        in_cnt++;
        if (first_in_cyc < 0) first_in_cyc = cyc;
      end
      if (smp_valid && rdy_model) begin
        fill_q.push_back(int'(smp_data));
        smp_cnt++;
        if (smp_last || fill_q.size() == int'(MAX_COLS)) begin
          pend_q = fill_q;
          fill_q.delete();
          have_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input bit u, input bit l, input int xx, input int yy);
    bit acc;
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    x             = 16'(xx);
    y             = 16'(yy);
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > BUDGET) begin
        check("beat_accept_timeout", 32'(n), 32'(BUDGET));
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input bit rnd, input bit gaps, input int max_beats);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n == max_beats) return;
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send_beat(rnd ? 24'($urandom) : PIX, (r == 0 && c == 0), (c == w - 1), c, r);
        n++;
      end
    end
  endtask

  task automatic send_smp(input int v, input bit last);
    bit acc;
    int n = 0;
    smp_data  = 16'(v);
    smp_last  = last;
    smp_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = smp_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > BUDGET) begin
        check("smp_accept_timeout", 32'(n), 32'(BUDGET));
        break;
      end
    end
    smp_valid = 1'b0;
    smp_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  function automatic int count_not_pix();
    int k = 0;
    foreach (out_log[i]) if (out_log[i].d !== PIX) k++;
    return k;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("reset_m_data", 32'(m_axis_tdata), 32'd0);
    check("reset_m_user", 32'(m_axis_tuser), 32'd0);
    check("reset_m_last", 32'(m_axis_tlast), 32'd0);
    check("reset_smp_ready", 32'(smp_ready), 32'd1);
    check("reset_s_ready", 32'(s_axis_tready), 32'd1);
    @(posedge clk);
    #1;

    // No samples: pure pass-through, 2-beat latency.
    out_log.delete();
    send_frame(8, 4, 1'b0, 1'b0, -1);
    drain();
    check("t1_count", 32'(out_log.size()), 32'd32);
    check("t1_latency", 32'(first_out_cyc - first_in_cyc), 32'd2);
    check("t1_passthru", 32'(count_not_pix()), 32'd0);
    check("t1_sof", 32'(out_log[0].u), 32'd1);
    check("t1_eol", 32'(out_log[7].l), 32'd1);
    check("t1_nosof", 32'(out_log[8].u), 32'd0);

    // Diagonal trace 0..3.
    send_smp(0, 0); send_smp(1, 0); send_smp(2, 0); send_smp(3, 1);
    @(negedge clk);
    check("t2_smp_ready_full", 32'(smp_ready), 32'd0);
    @(posedge clk);
    #1;
    idle(3);
    out_log.delete();
    send_frame(8, 4, 1'b0, 1'b0, -1);
    drain();
    check("t2_x0y0", 32'(out_log[0].d), 32'(WAVE));
    check("t2_x1y1", 32'(out_log[9].d), 32'(WAVE));
    check("t2_x3y3", 32'(out_log[27].d), 32'(WAVE));
    check("t2_x1y0", 32'(out_log[1].d), 32'(PIX));
    check("t2_x4y0", 32'(out_log[4].d), 32'(PIX));
    check("t2_x3y1", 32'(out_log[11].d), 32'(PIX));

    // Trace 3,3,3,3 loaded mid-frame; shown from the next sof.
    out_log.delete();
    fork
      send_frame(8, 4, 1'b0, 1'b0, -1);
      begin
        idle(5);
        send_smp(3, 0); send_smp(3, 0); send_smp(3, 0); send_smp(3, 1);
      end
    join
    drain();
    check("t3_old_x1y1", 32'(out_log[9].d), 32'(WAVE));
    out_log.delete();
    send_frame(8, 4, 1'b0, 1'b0, -1);
    drain();
    check("t3_swap_on_sof", 32'(out_log[0].d), 32'(PIX));
    check("t3_x0y3", 32'(out_log[24].d), 32'(WAVE));
    check("t3_x1y1", 32'(out_log[9].d), 32'(PIX));

    // Random backpressure and input gaps.
    in_cnt = 0;
    out_cnt = 0;
    rdy_mode = 1;
    send_frame(8, 4, 1'b1, 1'b1, -1);
    send_frame(8, 4, 1'b1, 1'b1, -1);
    drain();
    rdy_mode = 0;
    idle(2);
    check("t4_in_count", 32'(in_cnt), 32'd64);
    check("t4_out_count", 32'(out_cnt), 32'd64);

    // MAX_COLS+3 samples without last.
    smp_cnt = 0;
    out_log.delete();
    fork
      for (int i = 0; i < int'(MAX_COLS) + 3; i++) send_smp(i % 4, 1'b0);
      begin
        int n = 0;
        while (smp_cnt < int'(MAX_COLS) && n < BUDGET) begin
          idle(1);
          n++;
        end
        idle(4);
        @(negedge clk);
        check("t5_stalled", 32'(smp_ready), 32'd0);
        check("t5_accepted", 32'(smp_cnt), 32'(MAX_COLS));
        @(posedge clk);
        #1;
        send_frame(20, 4, 1'b0, 1'b0, -1);
      end
    join
    drain();
    check("t5_x4y0", 32'(out_log[4].d), 32'(WAVE));
    check("t5_x15y3", 32'(out_log[75].d), 32'(WAVE));
    check("t5_x16y0", 32'(out_log[16].d), 32'(PIX));
    check("t5_x17y1", 32'(out_log[37].d), 32'(PIX));
    check("t5_total_smp", 32'(smp_cnt), 32'(MAX_COLS + 3));

    // Reset pulsed mid-frame after a commit.
    send_smp(1, 0); send_smp(1, 1);
    send_frame(8, 4, 1'b0, 1'b0, 10);
    check("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_immediate", 32'(m_axis_tvalid), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    out_log.delete();
    send_frame(8, 4, 1'b0, 1'b0, -1);
    drain();
    check("t6_count", 32'(out_log.size()), 32'd32);
    check("t6_passthru", 32'(count_not_pix()), 32'd0);

    // Constant trace of 2: equality vs fill.
    send_smp(2, 0); send_smp(2, 0); send_smp(2, 0); send_smp(2, 1);
    out_log.delete();
    send_frame(4, 4, 1'b0, 1'b0, -1);
    drain();
    check("t7_x1y2", 32'(out_log[9].d), 32'(WAVE));
    check("t7_x1y1", 32'(out_log[5].d), 32'(PIX));
`ifdef WAVE_OVERLAY_FILL_EN
    check("t7_x1y3", 32'(out_log[13].d), 32'(WAVE));
`else
    check("t7_x1y3", 32'(out_log[13].d), 32'(PIX));
`endif

    // Randomized traces and frames.
    rdy_mode = 1;
    for (int it = 0; it < 4; it++) begin
      int w = $urandom_range(1, 20);
      int h = $urandom_range(1, 6);
      int n = $urandom_range(1, MAX_COLS);
      fork
        begin
          send_frame(w, h, 1'b1, 1'b1, -1);
          send_frame(w, h, 1'b1, 1'b1, -1);
        end
        for (int i = 0; i < n; i++) send_smp($urandom_range(0, h), (i == n - 1));
      join
      drain();
    end
    rdy_mode = 0;
    idle(4);

    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
